conv_window_slider: RTL and testbench
=====================================

Name: conv_window_slider

Overview:
- Sits directly downstream of the padding stage.
- Accepts one set of three zero-padded image rows per channel (R, G, B) and streams 3x3 windows left to right, stride 1.
- Emits one window per cycle on a valid/ready interface feeding the first convolution MAC array.
- Tracks column and row position, and flags end of row and end of frame.

Parameters:
- IMG_W, 416, unpadded image width; padded row width PAD_W = IMG_W+2.
- IMG_H, 416, output rows per frame (row sets accepted per frame).
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  row set present on *_rows_in
- in_ready  out  1  block can accept a row set
- r_rows_in  in  3*PAD_W*PIX_W  R rows; row k at [k*PAD_W*PIX_W +: PAD_W*PIX_W]; pixel j of a row at [j*PIX_W +: PIX_W], pixel 0 = left pad
- g_rows_in  in  3*PAD_W*PIX_W  G rows, same packing
- b_rows_in  in  3*PAD_W*PIX_W  B rows, same packing
- out_valid  out  1  window outputs valid
- out_ready  in  1  consumer accepts window
- win_r  out  9*PIX_W  R window; tap (row r, col c) at [(3r+c)*PIX_W +: PIX_W]
- win_g  out  9*PIX_W  G window, same packing
- win_b  out  9*PIX_W  B window, same packing
- col_idx  out  9  output column of current window, 0..IMG_W-1
- row_idx  out  9  output row of current row set, 0..IMG_H-1
- row_done  out  1  one-cycle pulse after last window of a row is accepted
- frame_done  out  1  one-cycle pulse coincident with row_done for row IMG_H-1

Behaviour:
- Reset values (async, all clear): state=IDLE, col_idx=0, row_idx=0, row shift regs=0, out_valid=0, row_done=0, frame_done=0. in_ready=1 (it equals state==IDLE).
- FSM: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready, capture all nine rows into internal shift registers, col_idx<=0, go to STREAM.
- STREAM:
  - in_ready=0; in_valid is ignored and nothing is captured.
  - out_valid=1.
  - win_* taps come combinationally from pixels 0..2 of each captured row: tap (r,c) = pixel c of row r.
- Window accept (out_valid&out_ready):
  - Each row register shifts right by PIX_W (pixel 1 becomes pixel 0, zero fill at top).
  - If col_idx==IMG_W-1:
    - col_idx<=0, state<=IDLE, row_done<=1 next cycle.
    - If row_idx==IMG_H-1: row_idx<=0 (wrap) and frame_done<=1 next cycle; otherwise row_idx<=row_idx+1.
  - Otherwise col_idx<=col_idx+1.
- Backpressure: while out_valid&!out_ready, win_*, col_idx and row_idx hold stable.
- Latency and throughput:
  - Row set accepted in cycle N -> first window (col 0) valid in cycle N+1.
  - Full throughput is one window per cycle: IMG_W windows per row set.
  - One mandatory IDLE bubble cycle between row sets. With in_valid held high and out_ready=1, row sets are accepted every IMG_W+1 cycles.
- row_done and frame_done are registered pulses, high exactly one cycle, in the cycle after the final accept, which is also the IDLE cycle.
- Reset asserted mid-STREAM: immediate return to reset state; partial row is discarded; row_idx returns to 0.
- Widths: col_idx and row_idx are 9 bits. IMG_W and IMG_H are each ≤512.
- No arithmetic on pixel data: pixels pass through bit-exact.

Test Plan:
- Basic stream (IMG_W=4, IMG_H=2). Stimulus: R row k pixel j = 16k+j, out_ready=1. Required response:
  - in_ready drops cycle after accept.
  - 4 windows on consecutive cycles.
  - Window col 1 win_r taps = {1,2,3,17,18,19,33,34,35} in order (3r+c).
  - row_done pulses once after col 3; G and B are checked identically with offset data.
- Backpressure: toggle out_ready 1,0,0,1,... -> every window appears exactly once in column order. Outputs stay stable during stalls. col_idx never skips.
- Back-to-back (in_valid held 1, 3 row sets) -> accepts at cycles 0, 5, 10. Exactly one out_valid=0 cycle between rows. row_idx = 0,1,0.
- Frame wrap: IMG_H=2, two row sets -> frame_done pulses only with the second row_done. row_idx returns to 0. A third row set starts at row_idx 0.
- Reset mid-stream: assert reset at col_idx=2 -> out_valid=0, in_ready=1, col_idx=0, row_idx=0 immediately. No row_done pulse. Next row set streams from col 0.
- in_valid during STREAM with different data -> ignored. Windows continue from the originally captured rows.

Source files
------------

// File: rtl/conv_window_slider.sv
// conv_window_slider
//   Takes one zero-padded three-row set per channel (R, G, B) from the
//   padding stage. It then streams IMG_W 3x3 windows, left to right with
//   stride 1, to the first convolution MAC array.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     in_valid / in_ready   row-set handshake (in_ready == IDLE)
//     {r,g,b}_rows_in       3 padded rows; row k at [k*PAD_W*PIX_W +: ...],
//                           pixel j at [j*PIX_W +: PIX_W], pixel 0 = left pad
//     out_valid / out_ready window handshake (out_valid == STREAM)
//     win_{r,g,b}           3x3 taps; tap (r,c) at [(3r+c)*PIX_W +: PIX_W]
//     col_idx, row_idx      output column / row of the current window
//     row_done, frame_done  registered one-cycle pulses after a row's last
//                           window is accepted (frame_done for row IMG_H-1)

// One captured padded row. The window taps are always pixels 0..2, and an
// accept shifts the row one pixel left in image terms.
module conv_row_shreg #(
  parameter int PIX_W = 8,
  parameter int PAD_W = 418
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [PAD_W*PIX_W-1:0] din,
  output logic [3*PIX_W-1:0]     taps
);
  localparam int ROW_W = PAD_W*PIX_W;

  logic [ROW_W-1:0] row_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      row_q <= '0;
    else if (load)  row_q <= din;
    else if (shift) row_q <= {{PIX_W{1'b0}}, row_q[ROW_W-1:PIX_W]};
  end

  assign taps = row_q[3*PIX_W-1:0];
endmodule

module conv_window_slider #(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int PIX_W = 8,
  parameter int PAD_W = IMG_W + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3*PAD_W*PIX_W-1:0] r_rows_in,
  input  logic [3*PAD_W*PIX_W-1:0] g_rows_in,
  input  logic [3*PAD_W*PIX_W-1:0] b_rows_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9*PIX_W-1:0]       win_r,
  output logic [9*PIX_W-1:0]       win_g,
  output logic [9*PIX_W-1:0]       win_b,
  output logic [8:0]               col_idx,
  output logic [8:0]               row_idx,
  output logic                     row_done,
  output logic                     frame_done
);
  localparam int          ROW_W    = PAD_W*PIX_W;
  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  STREAM   = 1'b1;
  localparam logic [8:0]  LAST_COL = 9'(IMG_W - 1);
  localparam logic [8:0]  LAST_ROW = 9'(IMG_H - 1);

  logic [0:0] state;
  logic       load, accept;

  // Nine rows in channel-major order: 0..2 = R, 3..5 = G, 6..8 = B.
  logic [8:0][ROW_W-1:0]   rows_all;
  logic [8:0][3*PIX_W-1:0] taps_all;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == STREAM);
  assign load      = in_valid & in_ready;
  assign accept    = out_valid & out_ready;

  assign rows_all = {b_rows_in, g_rows_in, r_rows_in};

  genvar i;
  generate
    for (i = 0; i < 9; i++) begin : g_row
      conv_row_shreg #(.PIX_W(PIX_W), .PAD_W(PAD_W)) u_row (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .shift(accept),
        .din  (rows_all[i]),
        .taps (taps_all[i])
      );
    end
  endgenerate

  // Row r contributes taps (r,0..2) contiguously, so the packed slices
  // already match the (3r+c) window layout.
  assign win_r = taps_all[2:0];
  assign win_g = taps_all[5:3];
  assign win_b = taps_all[8:6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col_idx    <= '0;
      row_idx    <= '0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      if (load) begin
        state   <= STREAM;
        col_idx <= '0;
      end else if (accept) begin
        if (col_idx == LAST_COL) begin
          state    <= IDLE;
          col_idx  <= '0;
          row_done <= 1'b1;
          if (row_idx == LAST_ROW) begin
            row_idx    <= '0;
            frame_done <= 1'b1;
          end else begin
            row_idx <= row_idx + 9'd1;
          end
        end else begin
          col_idx <= col_idx + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_window_slider.sv
module tb_conv_window_slider;
  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int PIX_W = 8;
  localparam int PAD_W = IMG_W + 2;
  localparam int RW    = 3*PAD_W*PIX_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] r_rows_in = '0, g_rows_in = '0, b_rows_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [71:0]   win_r, win_g, win_b;
  logic [8:0]    col_idx, row_idx;
  logic          row_done, frame_done;

  int total = 0;
  int bad   = 0;

  conv_window_slider #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .r_rows_in(r_rows_in), .g_rows_in(g_rows_in), .b_rows_in(b_rows_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .win_r(win_r), .win_g(win_g), .win_b(win_b),
    .col_idx(col_idx), .row_idx(row_idx),
    .row_done(row_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel j of row k for channel ch: base + 64*ch + 16*k + j
  function automatic logic [RW-1:0] mk(input int ch, input int base);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < PAD_W; j++)
        v[(k*PAD_W+j)*PIX_W +: PIX_W] = 8'(base + ch*64 + 16*k + j);
    return v;
  endfunction

  function automatic logic [71:0] ew(input int ch, input int base, input int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int t = 0; t < 3; t++)
        w[(3*r+t)*PIX_W +: PIX_W] = 8'(base + ch*64 + 16*r + c + t);
    return w;
  endfunction

  task automatic load_rows(input int base);
    r_rows_in = mk(0, base);
    g_rows_in = mk(1, base);
    b_rows_in = mk(2, base);
  endtask

  // Capture one row set and stream it. mode 1 toggles out_ready 1,0,0,...;
  // noise keeps in_valid high with other data during STREAM.
  task automatic run_row(input int base, input int mode, input bit noise,
                         input logic [8:0] exp_row, input bit exp_frame);
    int  ec;
    bit  done, acc;
    logic [8:0] nxt;
    load_rows(base);
    in_valid = 1'b1;
    chk("in_ready_idle", 72'(in_ready), 72'(1));
    tick();
    in_valid = noise;
    if (noise) load_rows(200);
    chk("in_ready_drop", 72'(in_ready), 72'(0));
    ec = 0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      out_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      chk("out_valid", 72'(out_valid), 72'(1));
      chk("col_idx", 72'(col_idx), 72'(ec));
      chk("row_idx", 72'(row_idx), 72'(exp_row));
      chk("win_r", 72'(win_r), ew(0, base, ec));
      chk("win_g", 72'(win_g), ew(1, base, ec));
      chk("win_b", 72'(win_b), ew(2, base, ec));
      if (base == 0 && ec == 1) begin
        chk("win_r_col1_hand", 72'(win_r),
            {8'd35, 8'd34, 8'd33, 8'd19, 8'd18, 8'd17, 8'd3, 8'd2, 8'd1});
        chk("win_g_col1_hand", 72'(win_g),
            {8'd99, 8'd98, 8'd97, 8'd83, 8'd82, 8'd81, 8'd67, 8'd66, 8'd65});
      end
      acc = out_ready;
      tick();
      if (acc) begin
        if (ec == IMG_W-1) done = 1'b1;
        else ec++;
      end
      if (done) in_valid = 1'b0;
      else chk("row_done_early", 72'(row_done), 72'(0));
    end
    nxt = (exp_row == 9'(IMG_H-1)) ? 9'd0 : exp_row + 9'd1;
    chk("row_finished", 72'(done), 72'(1));
    chk("row_done", 72'(row_done), 72'(1));
    chk("frame_done", 72'(frame_done), 72'(exp_frame));
    chk("out_valid_bubble", 72'(out_valid), 72'(0));
    chk("in_ready_bubble", 72'(in_ready), 72'(1));
    chk("col_idx_wrap", 72'(col_idx), 72'(0));
    chk("row_idx_next", 72'(row_idx), 72'(nxt));
    out_ready = 1'b1;
    tick();
    chk("row_done_pulse", 72'(row_done), 72'(0));
    chk("frame_done_pulse", 72'(frame_done), 72'(0));
  endtask

  initial begin
    int acc_cyc[$];
    logic [8:0] rows_seen[$];
    int zeros;

    // Reset state
    #3;
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_col", 72'(col_idx), 72'(0));
    chk("rst_row", 72'(row_idx), 72'(0));
    chk("rst_row_done", 72'(row_done), 72'(0));
    chk("rst_win_r", 72'(win_r), 72'(0));
    tick();
    reset = 1'b0;
    tick();

    // Basic stream, row 0
    run_row(0, 0, 1'b0, 9'd0, 1'b0);
    // Backpressure on row 1, which also wraps the frame
    run_row(5, 1, 1'b0, 9'd1, 1'b1);

    // Back-to-back: in_valid held high for three row sets
    load_rows(20);
    in_valid = 1'b1; out_ready = 1'b1; zeros = 0;
    for (int c = 0; c < 15; c++) begin
      if (!out_valid) zeros++;
      if (in_valid && in_ready) acc_cyc.push_back(c);
      if (out_valid && col_idx == 9'd0) rows_seen.push_back(row_idx);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 72'(acc_cyc.size()), 72'(3));
    if (acc_cyc.size() == 3) begin
      chk("b2b_acc0", 72'(acc_cyc[0]), 72'(0));
      chk("b2b_acc1", 72'(acc_cyc[1]), 72'(5));
      chk("b2b_acc2", 72'(acc_cyc[2]), 72'(10));
    end
    chk("b2b_bubbles", 72'(zeros), 72'(3));
    chk("b2b_rows_n", 72'(rows_seen.size()), 72'(3));
    if (rows_seen.size() == 3) begin
      chk("b2b_row0", 72'(rows_seen[0]), 72'(0));
      chk("b2b_row1", 72'(rows_seen[1]), 72'(1));
      chk("b2b_row2", 72'(rows_seen[2]), 72'(0));
    end
    chk("b2b_row_after", 72'(row_idx), 72'(1));

    // Reset mid-stream at col_idx 2
    load_rows(30);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("mid_col2", 72'(col_idx), 72'(2));
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 72'(out_valid), 72'(0));
    chk("mid_rst_in_ready", 72'(in_ready), 72'(1));
    chk("mid_rst_col", 72'(col_idx), 72'(0));
    chk("mid_rst_row", 72'(row_idx), 72'(0));
    #2 reset = 1'b0;
    tick();
    chk("mid_no_row_done", 72'(row_done), 72'(0));
    chk("mid_idle", 72'(out_valid), 72'(0));
    run_row(40, 0, 1'b0, 9'd0, 1'b0);

    // in_valid during STREAM with different data is ignored
    run_row(50, 0, 1'b1, 9'd1, 1'b1);
    chk("final_row_idx", 72'(row_idx), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #20000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
